// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples CHUNK bits per clock,
// with valid/ready handshakes on the operand and result sides.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic [31:0]      base;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             ripple_c;
    logic             c_chunk;
    logic             c_msb;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

    assign base    = 32'(cnt) * 32'(CHUNK);
    assign last    = (cnt == CW'(NCHUNK - 1));
    assign a_chunk = CHUNK'(a_q >> base);
    assign b_chunk = CHUNK'(b_q >> base);

    // Bit-level ripple so the carry entering the chunk's top bit is visible;
    // on the last chunk that is the carry into the word's MSB.
    always_comb begin
        ripple_c = carry_q;
        c_msb    = carry_q;
        s_chunk  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = ripple_c;
            s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ ripple_c;
            ripple_c   = (a_chunk[i] & b_chunk[i]) | (ripple_c & (a_chunk[i] ^ b_chunk[i]));
        end
        c_chunk = ripple_c;
    end

    // Subtraction is a + ~b + ~cin, so B and the carry are inverted on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum     <= (sum & ~(CHUNK_MASK << base)) | (WIDTH'(s_chunk) << base);
                    carry_q <= c_chunk;
                    if (last) begin
                        cout  <= c_chunk;
                        ovf   <= c_msb ^ c_chunk;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and reference-model checks of chunked_addsub, including
// backpressure, asynchronous reset mid-operation and several WIDTH/CHUNK pairs.
module tb_chunked_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic        sw_cin;
    logic        sw_sub;
    logic [2:0]  sw_valid;
    logic        sw_oready;
    logic [2:0]  sw_iready;
    logic [2:0]  sw_ovalid;
    logic [2:0]  sw_cout;
    logic [2:0]  sw_ovf;
    logic [2:0]  sw_busy;
    logic [15:0] s_c16;
    logic [15:0] s_c1;
    logic [31:0] s_w32;

    int n_assert = 0;
    int n_fail   = 0;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_iready[0]),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovalid[0]),
        .out_ready(sw_oready), .sum(s_c16), .cout(sw_cout[0]), .ovf(sw_ovf[0]), .busy(sw_busy[0])
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_iready[1]),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovalid[1]),
        .out_ready(sw_oready), .sum(s_c1), .cout(sw_cout[1]), .ovf(sw_ovf[1]), .busy(sw_busy[1])
    );

    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_iready[2]),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovalid[2]),
        .out_ready(sw_oready), .sum(s_w32), .cout(sw_cout[2]), .ovf(sw_ovf[2]), .busy(sw_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin, input logic vsub);
        @(negedge clk);
        checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called #1 after an accepting edge; counts edges until out_valid.
    task automatic waitDone(output int lat, output logic bad);
        lat = 0;
        bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("out_valid after handshake", {31'd0, out_valid}, 32'd0);
        checkOutput("in_ready after handshake", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub,
                         input logic [15:0] es, input logic ec, input logic eo);
        int   lat;
        logic bad;
        applyStimulus(va, vb, vcin, vsub);
        waitDone(lat, bad);
        checkOutput({tag, " latency"}, 32'(lat), 32'd4);
        checkOutput({tag, " in_ready low/busy high in RUN"}, {31'd0, bad}, 32'd0);
        checkOutput({tag, " sum"}, {16'd0, sum}, {16'd0, es});
        checkOutput({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        releaseResult();
    endtask

    // Independent reference: wide unsigned arithmetic for sum/cout and
    // signed range test on the true result for overflow.
    task automatic refModel(input int w, input logic [31:0] va, input logic [31:0] vb,
                            input logic vcin, input logic vsub,
                            output logic [31:0] es, output logic ec, output logic eo);
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] r;
        logic [63:0] m;
        longint      sa;
        longint      sb;
        longint      t;
        longint      lim;
        m   = (64'd1 << w) - 64'd1;
        ua  = {32'd0, va} & m;
        ub  = {32'd0, vb} & m;
        lim = longint'(1) <<< (w - 1);
        sa  = ua[w-1] ? longint'(ua) - (lim * 2) : longint'(ua);
        sb  = ub[w-1] ? longint'(ub) - (lim * 2) : longint'(ub);
        if (!vsub) begin
            r  = ua + ub + 64'(vcin);
            ec = r[w];
            t  = sa + sb + longint'(vcin);
        end else begin
            r  = ua - ub - 64'(vcin);
            ec = (ua >= ub + 64'(vcin));
            t  = sa - sb - longint'(vcin);
        end
        es = 32'(r & m);
        eo = (t > lim - 1) || (t < -lim);
    endtask

    task automatic getSweep(input int idx, output logic [31:0] os, output logic oc,
                            output logic oo, output logic ov);
        case (idx)
            0:       os = {16'd0, s_c16};
            1:       os = {16'd0, s_c1};
            default: os = s_w32;
        endcase
        oc = sw_cout[idx];
        oo = sw_ovf[idx];
        ov = sw_ovalid[idx];
    endtask

    task automatic runSweep(input int idx, input int w, input int exp_lat);
        logic [31:0] m;
        logic [31:0] va;
        logic [31:0] vb;
        logic        vcin;
        logic        vsub;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        logic [31:0] os;
        logic        oc;
        logic        oo;
        logic        ov;
        int          lat;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        va   = $urandom & m;
        vb   = $urandom & m;
        vcin = 1'($urandom_range(0, 1));
        vsub = 1'($urandom_range(0, 1));
        refModel(w, va, vb, vcin, vsub, es, ec, eo);
        @(negedge clk);
        sw_a          = va;
        sw_b          = vb;
        sw_cin        = vcin;
        sw_sub        = vsub;
        sw_valid[idx] = 1'b1;
        @(posedge clk);
        #1 sw_valid = 3'b000;
        lat = 0;
        getSweep(idx, os, oc, oo, ov);
        while (ov !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            getSweep(idx, os, oc, oo, ov);
        end
        checkOutput($sformatf("sweep%0d latency", idx), 32'(lat), 32'(exp_lat));
        checkOutput($sformatf("sweep%0d sum a=%h b=%h", idx, va, vb), os, es);
        checkOutput($sformatf("sweep%0d cout", idx), {31'd0, oc}, {31'd0, ec});
        checkOutput($sformatf("sweep%0d ovf", idx), {31'd0, oo}, {31'd0, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   lat;
        logic bad;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        sw_a      = '0;
        sw_b      = '0;
        sw_cin    = 1'b0;
        sw_sub    = 1'b0;
        sw_valid  = 3'b000;
        sw_oready = 1'b1;

        #12;
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset sum", {16'd0, sum}, 32'd0);
        checkOutput("reset cout/ovf", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed add/sub vectors");
        runOp("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runOp("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("add 7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("add 00FF+0F00+1", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        runOp("sub 0005-0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runOp("sub 8000-0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runOp("sub 0010-0003-1", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        runOp("sub 0000-0000", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(16'hF000, 16'h2000, 1'b0, 1'b0);
        waitDone(lat, bad);
        checkOutput("bp first latency", 32'(lat), 32'd4);
        checkOutput("bp first sum", {16'd0, sum}, 32'h0000_1000);
        @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp held sum", {16'd0, sum}, 32'h0000_1000);
            checkOutput("bp held cout/ovf", {30'd0, cout, ovf}, 32'd2);
            checkOutput("bp in_ready low", {31'd0, in_ready}, 32'd0);
            checkOutput("bp out_valid held", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("bp second accepted", {30'd0, in_ready, busy}, 32'd1);
        waitDone(lat, bad);
        checkOutput("bp second latency", 32'(lat), 32'd4);
        checkOutput("bp second sum", {16'd0, sum}, 32'h0000_FFFF);
        checkOutput("bp second cout/ovf", {30'd0, cout, ovf}, 32'd0);
        releaseResult();

        $display("[TB] asynchronous reset mid-operation");
        runOp("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h1234, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("partial sum after 2 chunks", {16'd0, sum}, 32'h0000_0035);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("async reset out_valid/busy", {30'd0, out_valid, busy}, 32'd0);
        checkOutput("async reset sum", {16'd0, sum}, 32'd0);
        checkOutput("async reset cout/ovf", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] parameter sweep against reference model");
        for (int i = 0; i < 1000; i++) runSweep(0, 16, 1);
        for (int i = 0; i < 1000; i++) runSweep(1, 16, 16);
        for (int i = 0; i < 1000; i++) runSweep(2, 32, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
